// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: downstream control, instruction memory port and
// the presented instruction.
//   master : used by fetch_ctrl (drives imem_req/imem_addr/inst*/pc)
//   slave  : used by the environment (drives stall/redirect/imem_ack/rdata)
interface fetch_if;
  localparam int unsigned XLEN = 32;

  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;
  logic            inst_valid;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;
  logic [XLEN-1:0] pc;

  modport master (
    input  stall, redirect_valid, redirect_pc, imem_ack, imem_rdata,
    output imem_req, imem_addr, inst_valid, inst, inst_pc, pc
  );

  modport slave (
    output stall, redirect_valid, redirect_pc, imem_ack, imem_rdata,
    input  imem_req, imem_addr, inst_valid, inst, inst_pc, pc
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues sequential reads to instruction
// memory, presents one instruction at a time downstream, and handles taken
// redirects (dropping an in-flight read when one is outstanding).
//   clk, reset : clock, synchronous active-high reset
//   bus        : fetch_if.master (stall/redirect in, imem port, inst out, pc)
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic     clk,
  input  logic     reset,
  fetch_if.master  bus
);
  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {IDLE, FETCH, DISCARD} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic            inst_valid_q, inst_valid_d;

  logic            req_c;
  logic            ack_acc_c;
  logic            xfer_c;
  logic [XLEN-1:0] redir_pc_c;
  logic [XLEN-1:0] pc_inc_c;

  // Request whenever active and the output slot is free or draining.
  always_comb begin
    req_c      = (state_q != IDLE) && (!inst_valid_q || !bus.stall);
    ack_acc_c  = req_c && bus.imem_ack;
    xfer_c     = inst_valid_q && !bus.stall;
    redir_pc_c = {bus.redirect_pc[XLEN-1:2], 2'b00};
    pc_inc_c   = pc_q + XLEN'(PC_STEP);
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    addr_d       = addr_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;

    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
        addr_d  = pc_q;
        if (bus.redirect_valid) begin
          pc_d   = redir_pc_c;
          addr_d = redir_pc_c;
        end
      end
      FETCH: begin
        if (bus.redirect_valid) begin
          pc_d         = redir_pc_c;
          inst_valid_d = 1'b0;
          // An outstanding read must complete before the new target is sent.
          if (req_c && !bus.imem_ack) state_d = DISCARD;
          else                        addr_d  = redir_pc_c;
        end else if (ack_acc_c) begin
          inst_d       = bus.imem_rdata;
          inst_pc_d    = addr_q;
          inst_valid_d = 1'b1;
          pc_d         = pc_inc_c;
          addr_d       = pc_inc_c;
        end else if (xfer_c) begin
          inst_valid_d = 1'b0;
        end
      end
      DISCARD: begin
        inst_valid_d = 1'b0;
        if (bus.redirect_valid) begin
          pc_d = redir_pc_c;
        end else if (ack_acc_c) begin
          addr_d  = pc_q;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      addr_q       <= RESET_PC;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      addr_q       <= addr_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  assign bus.imem_req   = req_c;
  assign bus.imem_addr  = addr_q;
  assign bus.inst_valid = inst_valid_q;
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;
  assign bus.pc         = pc_q;
endmodule
